// File: rtl/tcm_inst_reader.sv
// -----------------------------------------------------------------------------
// tcm_inst_reader
//
// Read-back engine for the instruction TCM. A start pulse walks a fixed window
// of WORDS 32-bit words starting at BASE_ADDR. Each word is read through the
// TCM read port and presented on a valid/ready stream with its byte address.
// The first word equal to HALT_INST is recorded as a sticky flag and an
// address. With STOP_ON_HALT set, the dump also ends at that word.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle dump request (ignored while busy)
//   mem_rd_o       TCM read strobe
//   mem_addr_o     TCM byte address (0 when no read is issued)
//   mem_data_i     TCM read data, valid the cycle after mem_rd_o
//   out_valid_o    output word valid
//   out_ready_i    consumer ready
//   out_data_o     instruction word
//   out_addr_o     byte address of out_data_o
//   out_last_o     final word of the dump
//   busy_o         dump in progress
//   done_o         one-cycle pulse after the final handshake
//   halt_found_o   sticky: a halt word was seen in this dump
//   halt_addr_o    address of the first halt word
//
// State table
//   S_IDLE | waiting for start_i; halt result of last dump held
//   S_RD   | TCM read issued for word idx
//   S_WAIT | TCM data returning; captured into the output register
//   S_OUT  | output word presented, waiting for out_ready_i
//   S_DONE | done_o pulse, start_i ignored
// -----------------------------------------------------------------------------
module tcm_inst_reader #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned WORDS        = 100,
    parameter logic [31:0] HALT_INST    = 32'h0000_8067,
    parameter bit          STOP_ON_HALT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [31:0] out_addr_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        halt_found_o,
    output logic [31:0] halt_addr_o
);

    localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] idx_q;
    logic [31:0] rd_addr;
    logic        is_halt;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [31:0] out_addr_q;
    logic        out_last_q;
    logic        halt_found_q;
    logic [31:0] halt_addr_q;

    // idx is unchanged between RD and WAIT, so the same sum serves as both
    // the read address and the captured word address. Wraps modulo 2^32.
    assign rd_addr = BASE_ADDR + {14'd0, idx_q, 2'b00};
    assign is_halt = (mem_data_i == HALT_INST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_RD;
            S_RD:   state_d = S_WAIT;
            S_WAIT: state_d = S_OUT;
            S_OUT:  if (out_ready_i) state_d = out_last_q ? S_DONE : S_RD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= 16'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'd0;
            out_addr_q   <= 32'd0;
            out_last_q   <= 1'b0;
            halt_found_q <= 1'b0;
            halt_addr_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_q        <= 16'd0;
                        halt_found_q <= 1'b0;
                        halt_addr_q  <= 32'd0;
                    end
                end
                S_WAIT: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= mem_data_i;
                    out_addr_q  <= rd_addr;
                    out_last_q  <= (idx_q == LAST_IDX) || (STOP_ON_HALT && is_halt);
                    // Only the first halt of a dump is recorded.
                    if (is_halt && !halt_found_q) begin
                        halt_found_q <= 1'b1;
                        halt_addr_q  <= rd_addr;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (!out_last_q) idx_q <= idx_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_o     = (state_q == S_RD);
    assign mem_addr_o   = mem_rd_o ? rd_addr : 32'd0;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_addr_o   = out_addr_q;
    assign out_last_o   = out_last_q;
    assign halt_found_o = halt_found_q;
    assign halt_addr_o  = halt_addr_q;

endmodule
